// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce / edge-detect block.
package debounce_pkg;

    // Debounce FSM: two stable states and two qualifying states
    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } dbc_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_EVT_CNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear/reset to zero
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronised level into a clean level plus one-cycle
// rise/fall pulses. Optional accepted-rise event counter is enabled by
// defining DEBOUNCE_EVT_CNT_EN (adds evt_clr_i / evt_cnt_o ports).
import debounce_pkg::*;

module debounce_edge_detect #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int EVT_CNT_W       = DEF_EVT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_sig_i,
    output logic                 level_o,
    output logic                 rise_o,
    output logic                 fall_o
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    input  logic                 evt_clr_i,
    output logic [EVT_CNT_W-1:0] evt_cnt_o
`endif
);

    localparam int              QW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [QW-1:0]   QMAX = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [QW-1:0]   QONE = QW'(1);

    dbc_state_e    state;
    logic [QW-1:0] qcnt;

    // Debounce FSM: qcnt counts consecutive samples at the candidate level;
    // the first sample (seen in the stable state) counts as 1, so acceptance
    // happens on the N-th consecutive sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_LO;
            qcnt    <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            case (state)
                ST_LO: begin
                    if (sync_sig_i) begin
                        state <= CHK_HI;
                        qcnt  <= QONE;
                    end
                end
                CHK_HI: begin
                    if (!sync_sig_i) begin
                        state <= ST_LO;
                    end else if (qcnt == QMAX) begin
                        state   <= ST_HI;
                        level_o <= 1'b1;
                        rise_o  <= 1'b1;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                end
                ST_HI: begin
                    if (!sync_sig_i) begin
                        state <= CHK_LO;
                        qcnt  <= QONE;
                    end
                end
                CHK_LO: begin
                    if (sync_sig_i) begin
                        state <= ST_HI;
                    end else if (qcnt == QMAX) begin
                        state   <= ST_LO;
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                end
                default: state <= ST_LO;
            endcase
        end
    end

`ifdef DEBOUNCE_EVT_CNT_EN
    logic accept_rise;

    // Same condition that sets rise_o, so the count lands with the pulse
    always_comb begin
        accept_rise = (state == CHK_HI) && sync_sig_i && (qcnt == QMAX);
    end

    sat_counter #(
        .W   (EVT_CNT_W)
    ) u_evt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept_rise),
        .clr (evt_clr_i),
        .cnt (evt_cnt_o)
    );
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect (N=4, counter width 3). Counter checks
// apply only when DEBOUNCE_EVT_CNT_EN is defined.
module tb_debounce_edge_detect;

    localparam int N     = 4;
    localparam int W     = 3;
    localparam int CMAX  = (1 << W) - 1;
    localparam int NVEC  = 23;

    logic clk = 1'b0;
    logic rst, sig, clr;
    logic level_o, rise_o, fall_o;
    logic [W-1:0] evt_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference: level plus a run-length of samples disagreeing with it
    bit m_lvl, m_rise, m_fall;
    int m_run, m_cnt;

    typedef struct {
        bit r, s, c;
        bit l, ri, f;
        int cnt;
    } vec_t;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    debounce_edge_detect #(
        .DEBOUNCE_CYCLES (N),
        .EVT_CNT_W       (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_sig_i (sig),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o)
`ifdef DEBOUNCE_EVT_CNT_EN
        ,
        .evt_clr_i  (clr),
        .evt_cnt_o  (evt_cnt_o)
`endif
    );

`ifndef DEBOUNCE_EVT_CNT_EN
    assign evt_cnt_o = '0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit l, input bit ri, input bit f, input int c);
        chk({tag, ".level"}, int'(level_o), int'(l));
        chk({tag, ".rise"},  int'(rise_o),  int'(ri));
        chk({tag, ".fall"},  int'(fall_o),  int'(f));
`ifdef DEBOUNCE_EVT_CNT_EN
        chk({tag, ".cnt"},   int'(evt_cnt_o), c);
`endif
    endtask

    // Drive one cycle, advance the model, sample 1ns after the edge
    task automatic step(input bit r, input bit s, input bit c);
        rst = r; sig = s; clr = c;
        @(posedge clk);
        if (r) begin
            m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
        end else begin
            m_rise = 0; m_fall = 0;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == N) begin
                    m_lvl = s;
                    m_run = 0;
                    if (s) m_rise = 1; else m_fall = 1;
                end
            end else begin
                m_run = 0;
            end
            if (c) m_cnt = 0;
            else if (m_rise && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic step_m(input string tag, input bit r, input bit s, input bit c);
        step(r, s, c);
        chk_outs(tag, m_lvl, m_rise, m_fall, m_cnt);
    endtask

    function automatic vec_t mk(bit r, bit s, bit c, bit l, bit ri, bit f, int cnt);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.l = l; v.ri = ri; v.f = f; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        // Clean rise, fall with a one-sample glitch, 3-cycle glitch, rise+clear
        tbl[0]  = mk(1,0,0, 0,0,0, 0);
        tbl[1]  = mk(0,1,0, 0,0,0, 0);
        tbl[2]  = mk(0,1,0, 0,0,0, 0);
        tbl[3]  = mk(0,1,0, 0,0,0, 0);
        tbl[4]  = mk(0,1,0, 1,1,0, 1);
        tbl[5]  = mk(0,1,0, 1,0,0, 1);
        tbl[6]  = mk(0,0,0, 1,0,0, 1);
        tbl[7]  = mk(0,1,0, 1,0,0, 1);
        tbl[8]  = mk(0,0,0, 1,0,0, 1);
        tbl[9]  = mk(0,0,0, 1,0,0, 1);
        tbl[10] = mk(0,0,0, 1,0,0, 1);
        tbl[11] = mk(0,0,0, 0,0,1, 1);
        tbl[12] = mk(0,0,0, 0,0,0, 1);
        tbl[13] = mk(0,1,0, 0,0,0, 1);
        tbl[14] = mk(0,1,0, 0,0,0, 1);
        tbl[15] = mk(0,1,0, 0,0,0, 1);
        tbl[16] = mk(0,0,0, 0,0,0, 1);
        tbl[17] = mk(0,1,0, 0,0,0, 1);
        tbl[18] = mk(0,1,0, 0,0,0, 1);
        tbl[19] = mk(0,1,0, 0,0,0, 1);
        tbl[20] = mk(0,1,1, 1,1,0, 0);
        tbl[21] = mk(0,1,0, 1,0,0, 0);
        tbl[22] = mk(0,1,1, 1,0,0, 0);

        rst = 1; sig = 0; clr = 0;
        m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].c);
            chk_outs($sformatf("vec%0d", i), tbl[i].l, tbl[i].ri, tbl[i].f, tbl[i].cnt);
        end

        // Saturation: nine accepted rises leave the counter at all-ones
        step_m("sat_rst", 1, 0, 0);
        for (int r = 0; r < 9; r++) begin
            for (int j = 0; j < N; j++) step_m("sat_hi", 0, 1, 0);
            for (int j = 0; j < N; j++) step_m("sat_lo", 0, 0, 0);
        end
`ifdef DEBOUNCE_EVT_CNT_EN
        chk("sat_final", int'(evt_cnt_o), 7);
`endif

        // Reset two samples into a rise qualification
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        chk_outs("midrst", 0, 0, 0, 0);
        for (int j = 0; j < N - 1; j++) begin
            step(0, 1, 0);
            chk_outs($sformatf("requal%0d", j), 0, 0, 0, 0);
        end
        step(0, 1, 0);
        chk_outs("requal_acc", 1, 1, 0, 1);

        // Reset while high and mid fall-check: level drops with no fall pulse
        step(0, 0, 0);
        step(1, 0, 0);
        chk_outs("rst_hi", 0, 0, 0, 0);
        // Input high at reset release qualifies a full rise
        for (int j = 0; j < N - 1; j++) step_m("rel_hi", 0, 1, 0);
        step(0, 1, 0);
        chk_outs("rel_acc", 1, 1, 0, 1);

        // Random runs against the reference model
        for (int i = 0; i < 300; i++) begin
            bit s;
            int len;
            s   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * N);
            for (int j = 0; j < len; j++)
                step_m("rand", ($urandom_range(0, 199) == 0),
                       s, ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
